// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR ADC conversion sequencer.
package sar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DECIDE  = 3'd4,
        ST_HOLD    = 3'd5
    } sar_state_t;

    localparam int unsigned NBITS_DEF      = 8;
    localparam int unsigned NCH_DEF        = 4;
    localparam int unsigned SAMPLE_CYC_DEF = 4;
    localparam int unsigned SETTLE_CYC_DEF = 2;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned chw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_rr_arbiter.sv
// Round-robin arbiter: first requester after the last granted one wins.
module sar_rr_arbiter
    import sar_pkg::*;
#(
    parameter  int unsigned NCH = NCH_DEF,
    localparam int unsigned CHW = chw(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] i_req,
    input  logic           i_advance,
    output logic [NCH-1:0] o_gnt_c,
    output logic [CHW-1:0] o_idx_c
);

    logic [CHW-1:0] r_last;
    logic [CHW-1:0] w_k;
    logic           w_found;

    // Scan channels starting just after the last grant.
    always_comb begin
        o_gnt_c = '0;
        o_idx_c = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            w_k = CHW'((32'(r_last) + i) % NCH);
            if (!w_found && i_req[w_k]) begin
                o_gnt_c[w_k] = 1'b1;
                o_idx_c      = w_k;
                w_found      = 1'b1;
            end
        end
    end

    // Pointer starts at the top channel so channel 0 has priority after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= CHW'(NCH - 1);
        end else if (i_advance) begin
            r_last <= o_idx_c;
        end
    end

endmodule

// File: rtl/sar_conv_sequencer.sv
// SAR ADC sequencer: arbitrates requesters, runs sample and binary search,
// and returns each result with its channel tag through a one-entry buffer.
module sar_conv_sequencer
    import sar_pkg::*;
#(
    parameter  int unsigned NBITS      = NBITS_DEF,
    parameter  int unsigned NCH        = NCH_DEF,
    parameter  int unsigned SAMPLE_CYC = SAMPLE_CYC_DEF,
    parameter  int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    localparam int unsigned CHW        = chw(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   req,
    output logic [NCH-1:0]   gnt,
    output logic [CHW-1:0]   ch_sel,
    output logic             sample,
    output logic [NBITS-1:0] dac_code,
    output logic             cmp_clk,
    input  logic             cmp_out,
    output logic [NBITS-1:0] result,
    output logic [CHW-1:0]   result_ch,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    localparam int unsigned CNT_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int unsigned CNTW    = chw(CNT_MAX);
    localparam int unsigned BW      = chw(NBITS);

    sar_state_t       r_state, w_state_nxt;
    logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
    logic [BW-1:0]    r_bit, w_bit_nxt;
    logic [NBITS-1:0] r_code, w_code_nxt, w_trial, w_load_data;
    logic [NCH-1:0]   r_gnt, w_gnt_nxt, w_arb_gnt;
    logic [CHW-1:0]   r_ch, w_ch_nxt, w_arb_idx;
    logic [NBITS-1:0] r_result;
    logic [CHW-1:0]   r_result_ch;
    logic             r_valid;
    logic             w_advance, w_load, w_buf_free;

    sar_rr_arbiter #(.NCH(NCH)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req),
        .i_advance (w_advance),
        .o_gnt_c   (w_arb_gnt),
        .o_idx_c   (w_arb_idx)
    );

    assign w_buf_free = !r_valid || result_ready;
    // Current bit kept only if the comparator said Vin >= Vdac.
    assign w_trial    = cmp_out ? r_code : (r_code & ~(NBITS'(1) << r_bit));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state, datapath next values and buffer load decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_code_nxt  = r_code;
        w_gnt_nxt   = '0;
        w_ch_nxt    = r_ch;
        w_advance   = 1'b0;
        w_load      = 1'b0;
        w_load_data = '0;
        case (r_state)
            ST_IDLE: begin
                w_code_nxt = '0;
                if (|req) begin
                    w_gnt_nxt   = w_arb_gnt;
                    w_ch_nxt    = w_arb_idx;
                    w_advance   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (r_cnt == CNTW'(SAMPLE_CYC - 1)) begin
                    w_cnt_nxt   = '0;
                    w_code_nxt  = NBITS'(1) << (NBITS - 1);
                    w_bit_nxt   = BW'(NBITS - 1);
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == CNTW'(SETTLE_CYC - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_COMPARE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_COMPARE: w_state_nxt = ST_DECIDE;
            ST_DECIDE: begin
                if (r_bit != '0) begin
                    w_code_nxt  = w_trial | (NBITS'(1) << (r_bit - 1'b1));
                    w_bit_nxt   = r_bit - 1'b1;
                    w_state_nxt = ST_SETTLE;
                end else if (w_buf_free) begin
                    w_load      = 1'b1;
                    w_load_data = w_trial;
                    w_code_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_code_nxt  = w_trial;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_buf_free) begin
                    w_load      = 1'b1;
                    w_load_data = r_code;
                    w_code_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter, bit index, SAR code, grant pulse and channel select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_bit  <= BW'(NBITS - 1);
            r_code <= '0;
            r_gnt  <= '0;
            r_ch   <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_bit  <= w_bit_nxt;
            r_code <= w_code_nxt;
            r_gnt  <= w_gnt_nxt;
            r_ch   <= w_ch_nxt;
        end
    end

    // One-entry result buffer; a load wins over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_result_ch <= '0;
            r_valid     <= 1'b0;
        end else if (w_load) begin
            r_result    <= w_load_data;
            r_result_ch <= r_ch;
            r_valid     <= 1'b1;
        end else if (r_valid && result_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign gnt          = r_gnt;
    assign ch_sel       = r_ch;
    assign dac_code     = r_code;
    assign sample       = (r_state == ST_SAMPLE);
    assign cmp_clk      = (r_state == ST_COMPARE);
    assign busy         = (r_state != ST_IDLE);
    assign result       = r_result;
    assign result_ch    = r_result_ch;
    assign result_valid = r_valid;

endmodule

// File: doc/sar_conv_sequencer.md
# sar_conv_sequencer

Control sequencer for the user-area SAR ADC. It shares the single sample-and-hold, capacitor DAC and comparator between `NCH` requesters using round-robin arbitration. It runs the sample and binary-search phases bit by bit, MSB first, and returns each result with its channel tag over a valid/ready handshake. It sits between the Wishbone/GPIO-facing register logic and the `sar_logic` DAC switch driver, which consumes `dac_code`.

## Interface
- `NBITS`, 8: conversion resolution; width of `dac_code` and `result`.
- `NCH`, 4: number of requesters/analog channels; ≥2.
- `SAMPLE_CYC`, 4: cycles the sample switch is closed; ≥1.
- `SETTLE_CYC`, 2: DAC settle cycles per bit before the comparator strobe; ≥1.
- `clk`  in  1  single clock domain; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NCH  level conversion request per channel.
- `gnt`  out  NCH  one-hot, one-cycle pulse in the first SAMPLE cycle.
- `ch_sel`  out  $clog2(NCH)  analog mux select; held from grant to end of conversion.
- `sample`  out  1  sample switch closed.
- `dac_code`  out  NBITS  trial code to the DAC switch driver.
- `cmp_clk`  out  1  comparator latch strobe, one-cycle pulse.
- `cmp_out`  in  1  comparator decision; 1 = Vin ≥ Vdac; valid the cycle after `cmp_clk`.
- `result`  out  NBITS  converted code.
- `result_ch`  out  $clog2(NCH)  channel of `result`.
- `result_valid`  out  1  result buffer full.
- `result_ready`  in  1  consumer accepts the result.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Reset values: all outputs 0, state IDLE, RR pointer set so channel 0 has highest priority, bit index = NBITS-1.
- Reset mid-conversion aborts immediately. The result buffer is cleared and no partial result is emitted.
- FSM states: IDLE, SAMPLE, SETTLE, COMPARE, DECIDE, HOLD.
- IDLE: if `|req`, the round-robin arbiter picks the first requesting channel after the last granted one. The FSM latches it into `ch_sel` and moves to SAMPLE. `dac_code` = 0.
- SAMPLE: `sample`=1 for SAMPLE_CYC cycles. On exit, `dac_code` = 1<<(NBITS-1), bit index = NBITS-1, next state SETTLE.
- SETTLE: hold `dac_code` for SETTLE_CYC cycles, then go to COMPARE.
- COMPARE: `cmp_clk`=1 for one cycle, then go to DECIDE.
- DECIDE: sample `cmp_out`. If it is 0, clear the current bit. Then:
  - If the bit index > 0, set the next lower bit, decrement the index and go to SETTLE.
  - Otherwise the conversion is complete.
- Completion: if the buffer is free (`!result_valid`, or `result_valid && result_ready` in the same cycle), load `result`/`result_ch`, set `result_valid` and go to IDLE. Otherwise go to HOLD.
- HOLD: `busy`=1 and no arbitration. When the buffer frees, load the result and go to IDLE.
- The buffer clears on `result_valid && result_ready` when no load happens in the same cycle. A simultaneous load and accept replaces the contents and `result_valid` stays 1.
- `req` is sampled only in IDLE. Requesters drop `req` after `gnt`; a held `req` simply competes again.

## Timing
- With `req` seen in IDLE at cycle t0:
  - SAMPLE occupies t1..t(SAMPLE_CYC).
  - Each bit takes SETTLE_CYC+2 cycles.
  - `result_valid` rises at t0 + SAMPLE_CYC + NBITS·(SETTLE_CYC+2) + 1.
- With default parameters: `gnt` at t1, `result_valid` at t37, earliest next `gnt` at t38.
- `dac_code` changes only on SAMPLE→SETTLE and DECIDE→SETTLE edges, so it is stable throughout SETTLE and COMPARE.
- Outputs `sample`, `cmp_clk`, `gnt`, `busy` are decoded from registered state/counters. No combinational path from `req`/`cmp_out` to outputs.

## Structure
- Package `sar_pkg`: state enum `sar_state_t`, default parameter constants, and a `CHW = $clog2(NCH)` helper function.
- Sub-module `sar_rr_arbiter`: NCH-wide round-robin with an `advance` input (pulsed at grant). It outputs a one-hot grant and an encoded index.
- Top-level holds the FSM, sample/settle counter, bit index, code SAR register and result buffer.

## Test plan
- Bench comparator model `cmp_out = (vin >= dac_code)` latched on `cmp_clk`, vin=0xA5 on ch0 → `result`=0xA5, `result_ch`=0, `result_valid` exactly 37 cycles after the req cycle.
- vin=0x00 and vin=0xFF → results 0x00 and 0xFF. The `dac_code` sequence for 0xFF is 80,C0,E0,F0,F8,FC,FE,FF.
- `req`=4'b1111 held with `result_ready`=1 → `gnt` order 0001,0010,0100,1000,0001. `result_ch` follows 0,1,2,3,0.
- `result_ready`=0 with two back-to-back requests → second conversion ends in HOLD with `busy`=1 and no `gnt`. Raising `result_ready` for one cycle → second result loads next cycle and `result_valid` stays 1.
- `rst_n` low during bit 3 of a conversion → all outputs 0 asynchronously and no `result_valid`. After release, `req[2]` alone gets `gnt`=0100.
- Simultaneous accept and completion → no gap in `result_valid`, new `result` visible the next cycle.
